// File: rtl/ksa_pkg.sv
// ksa_pkg
//   Shared definitions for the key-search datapath.
//   - chk_state_e : result_ram_checker FSM states (IDLE, ISSUE, CHECK, DONE)
//   - CHAR_*      : bounds of the accepted plaintext alphabet (lowercase letters and space)
//   - MSG_DEPTH   : number of plaintext bytes held in the result RAM
//   - is_msg_char : helper that tells whether a byte belongs to the accepted alphabet
package ksa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LOW_A = 8'h61;
  localparam logic [7:0] CHAR_LOW_Z = 8'h7A;
  localparam int         MSG_DEPTH  = 32;

  function automatic logic is_msg_char(input logic [7:0] c);
    return (c == CHAR_SPACE) || ((c >= CHAR_LOW_A) && (c <= CHAR_LOW_Z));
  endfunction

endpackage

// File: rtl/char_validator.sv
// char_validator
//   Combinational check of one plaintext byte. Shared between the result RAM
//   checker and the key-search controller.
//   Ports:
//     char_in  in  DATA_W  byte under test
//     is_valid out 1       1 when char_in is a lowercase ASCII letter or a space
//   Any value wider than 8 bits whose upper bits are non-zero is invalid.
module char_validator
  import ksa_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] char_in,
  output logic              is_valid
);

  logic [7:0] low_byte;
  logic       upper_zero;

  generate
    if (DATA_W > 8) begin : g_wide
      assign upper_zero = (char_in[DATA_W-1:8] == '0);
      assign low_byte   = char_in[7:0];
    end else begin : g_narrow
      assign upper_zero = 1'b1;
      assign low_byte   = 8'(char_in);
    end
  endgenerate

  assign is_valid = upper_zero && is_msg_char(low_byte);

endmodule

// File: rtl/result_ram_checker.sv
// result_ram_checker
//   After the decryptor has written its plaintext into the result RAM, this
//   block reads bytes 0..DEPTH-1 and gives a pass/fail verdict: pass means
//   every byte is a lowercase ASCII letter or a space. It only reads the RAM.
//
//   Handshake: start is a request that is accepted only in IDLE or DONE.
//   Once accepted, busy stays high until the verdict is ready; done then
//   stays high (with pass/fail_index/bad_char stable) until the next
//   accepted start or reset. start while busy is ignored.
//
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     start                begin a scan (accepted in IDLE and DONE)
//     result_ram_address   read address, equal to the current byte index
//     result_ram_q         RAM data, valid the cycle after the address is presented
//     busy                 scan in progress (ISSUE or CHECK)
//     done                 verdict valid
//     pass                 1 = all scanned bytes valid (meaningful with done)
//     fail_index           index of the first invalid byte
//     bad_char             value of the first invalid byte
//     bad_count            number of invalid bytes (RESULT_CHECK_COUNT_EN only)
//     state_dbg            current FSM state, for observation
//
//   Build option RESULT_CHECK_COUNT_EN: when defined, the scan always covers
//   all DEPTH bytes and counts invalid ones; fail_index/bad_char still
//   report the first invalid byte. When undefined, the scan stops at the
//   first invalid byte.
//
//   Timing: two cycles per byte. ISSUE holds the address while the RAM
//   registers it; CHECK looks at the returned data.
module result_ram_checker
  import ksa_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = MSG_DEPTH,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] result_ram_address,
  input  logic [DATA_W-1:0] result_ram_q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_index,
  output logic [DATA_W-1:0] bad_char,
`ifdef RESULT_CHECK_COUNT_EN
  output logic [ADDR_W:0]   bad_count,
`endif
  output chk_state_e        state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  chk_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_index_q, fail_index_d;
  logic [DATA_W-1:0] bad_char_q, bad_char_d;
`ifdef RESULT_CHECK_COUNT_EN
  logic [ADDR_W:0]   bad_count_q, bad_count_d;
`endif

  logic byte_ok;

  char_validator #(
    .DATA_W (DATA_W)
  ) u_char_validator (
    .char_in  (result_ram_q),
    .is_valid (byte_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pass_q       <= 1'b0;
      fail_index_q <= '0;
      bad_char_q   <= '0;
`ifdef RESULT_CHECK_COUNT_EN
      bad_count_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pass_q       <= pass_d;
      fail_index_q <= fail_index_d;
      bad_char_q   <= bad_char_d;
`ifdef RESULT_CHECK_COUNT_EN
      bad_count_q  <= bad_count_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pass_d       = pass_q;
    fail_index_d = fail_index_q;
    bad_char_d   = bad_char_q;
`ifdef RESULT_CHECK_COUNT_EN
    bad_count_d  = bad_count_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        // A new scan wipes the previous verdict so nothing stale survives.
        if (start) begin
          state_d      = ISSUE;
          idx_d        = '0;
          pass_d       = 1'b0;
          fail_index_d = '0;
          bad_char_d   = '0;
`ifdef RESULT_CHECK_COUNT_EN
          bad_count_d  = '0;
`endif
        end
      end

      ISSUE: begin
        state_d = CHECK;
      end

      CHECK: begin
`ifdef RESULT_CHECK_COUNT_EN
        if (!byte_ok) begin
          // Only the first offender is recorded; later ones just count.
          if (bad_count_q == '0) begin
            fail_index_d = idx_q;
            bad_char_d   = result_ram_q;
          end
          bad_count_d = bad_count_q + 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          pass_d  = (bad_count_d == '0);
        end else begin
          state_d = ISSUE;
          idx_d   = idx_q + 1'b1;
        end
`else
        if (!byte_ok) begin
          state_d      = DONE;
          pass_d       = 1'b0;
          fail_index_d = idx_q;
          bad_char_d   = result_ram_q;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else begin
          state_d = ISSUE;
          idx_d   = idx_q + 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  assign result_ram_address = idx_q;
  assign busy               = (state_q == ISSUE) || (state_q == CHECK);
  assign done               = (state_q == DONE);
  assign pass               = pass_q;
  assign fail_index         = fail_index_q;
  assign bad_char           = bad_char_q;
`ifdef RESULT_CHECK_COUNT_EN
  assign bad_count          = bad_count_q;
`endif
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_result_ram_checker.sv
// Testbench for result_ram_checker: a synchronous RAM model, directed and
// random scans, a per-cycle comparison against a scan-level reference
// model, and literal expectations for the key scenarios.
module tb_result_ram_checker;
  import ksa_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 8;

`ifdef RESULT_CHECK_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic              busy, done, pass;
  logic [ADDR_W-1:0] fail_index;
  logic [DATA_W-1:0] bad_char;
  chk_state_e        state_dbg;
`ifdef RESULT_CHECK_COUNT_EN
  logic [ADDR_W:0]   bad_count;
`endif

  always #5 clk = ~clk;

  result_ram_checker #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .result_ram_address (ram_addr),
    .result_ram_q       (ram_q),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .fail_index         (fail_index),
    .bad_char           (bad_char),
`ifdef RESULT_CHECK_COUNT_EN
    .bad_count          (bad_count),
`endif
    .state_dbg          (state_dbg)
  );

  // Result RAM: registered read, one cycle after the address is presented.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) ram_q <= mem[ram_addr];

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_ok(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // ---------------- reference model ----------------
  // The model thinks in whole scans: when a scan is accepted it works out
  // the verdict and how many edges the scan lasts, then just counts edges.
  bit         m_run  = 0;
  bit         m_done = 0;
  int         m_e    = 0;
  int         m_end  = 0;
  int         m_last = 0;
  bit         m_pass = 0;
  int         m_fidx = 0;
  logic [7:0] m_bchar = 8'h00;
  int         m_bcnt = 0;

  task automatic model_accept();
    int first;
    int cnt;
    first = -1;
    cnt   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ref_ok(mem[i])) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
    m_run   = 1;
    m_done  = 0;
    m_e     = 0;
    m_pass  = (first < 0);
    m_fidx  = (first < 0) ? 0 : first;
    m_bchar = (first < 0) ? 8'h00 : mem[first];
    m_bcnt  = cnt;
    if (COUNT_EN || first < 0) begin
      m_end  = 2 * DEPTH;
      m_last = DEPTH - 1;
    end else begin
      m_end  = 2 * first + 2;
      m_last = first;
    end
  endtask

  // Compare process: at every falling edge, check the DUT against the
  // model, then advance the model with the inputs the next rising edge
  // will sample (drivers change inputs 2ns after a rising edge).
  initial begin
    chk_state_e exp_st;
    int         exp_addr;
    forever begin
      @(negedge clk);
      exp_addr = m_run ? (m_e / 2) : (m_done ? m_last : 0);
      if (m_run)       exp_st = (m_e % 2 == 0) ? ISSUE : CHECK;
      else if (m_done) exp_st = DONE;
      else             exp_st = IDLE;
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("address", 32'(ram_addr), 32'(exp_addr));
      chk("state", 32'(state_dbg), 32'(exp_st));
      if (!m_run) begin
        chk("pass", 32'(pass), 32'(m_done ? m_pass : 1'b0));
        chk("fail_index", 32'(fail_index), m_done ? 32'(m_fidx) : 32'd0);
        chk("bad_char", 32'(bad_char), m_done ? 32'(m_bchar) : 32'd0);
`ifdef RESULT_CHECK_COUNT_EN
        chk("bad_count", 32'(bad_count), m_done ? 32'(m_bcnt) : 32'd0);
`endif
      end

      if (reset) begin
        m_run = 0; m_done = 0; m_e = 0; m_end = 0; m_last = 0;
        m_pass = 0; m_fidx = 0; m_bchar = 8'h00; m_bcnt = 0;
      end else if (start && !m_run) begin
        model_accept();
      end else if (m_run) begin
        m_e++;
        if (m_e == m_end) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < DEPTH; i++) mem[i] = v;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    if ($urandom_range(0, 19) == 0) begin
      b = 8'($urandom_range(0, 255));
      while (ref_ok(b)) b = 8'($urandom_range(0, 255));
    end else begin
      int r;
      r = $urandom_range(0, 26);
      b = (r == 26) ? 8'h20 : 8'(8'h61 + r);
    end
    return b;
  endfunction

  // Pulses start, then counts edges until done is seen. Optional extra
  // start pulses are sampled at edges p1 and p2 of the scan.
  task automatic run_scan(input int p1, input int p2, output int lat);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (lat == 0) chk("done_drops_after_start", 32'(done), 32'd0);
      if (done) break;
      @(posedge clk);
      lat++;
      #2 start = ((lat + 1) == p1) || ((lat + 1) == p2);
    end
    start = 1'b0;
    if (lat >= 200) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int         lat;
  logic [7:0] edge_vals [3];

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill(8'h61);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_addr", 32'(ram_addr), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));

    // Clean scan of 'a' bytes.
    fill(8'h61);
    run_scan(-1, -1, lat);
    chk("clean_latency", 32'(lat), 32'd64);
    chk("clean_pass", 32'(pass), 32'd1);
    chk("clean_last_addr", 32'(ram_addr), 32'd31);

    // Byte 7 is 'A'.
    fill(8'h61);
    mem[7] = 8'h41;
    run_scan(-1, -1, lat);
    chk("b7_latency", 32'(lat), COUNT_EN ? 32'd64 : 32'd16);
    chk("b7_pass", 32'(pass), 32'd0);
    chk("b7_fail_index", 32'(fail_index), 32'd7);
    chk("b7_bad_char", 32'(bad_char), 32'h41);
`ifdef RESULT_CHECK_COUNT_EN
    chk("b7_bad_count", 32'(bad_count), 32'd1);
`endif

    // Alphabet boundaries that must pass.
    for (int i = 0; i < DEPTH; i++) mem[i] = (i % 3 == 0) ? 8'h20 : ((i % 3 == 1) ? 8'h61 : 8'h7A);
    run_scan(-1, -1, lat);
    chk("bounds_pass", 32'(pass), 32'd1);

    // Just-outside values in the last slot.
    edge_vals[0] = 8'h7B;
    edge_vals[1] = 8'h60;
    edge_vals[2] = 8'h1F;
    for (int v = 0; v < 3; v++) begin
      fill(8'h7A);
      mem[31] = edge_vals[v];
      run_scan(-1, -1, lat);
      chk("last_latency", 32'(lat), 32'd64);
      chk("last_pass", 32'(pass), 32'd0);
      chk("last_fail_index", 32'(fail_index), 32'd31);
      chk("last_bad_char", 32'(bad_char), 32'(edge_vals[v]));
    end

    // Two bad bytes: only the first is reported.
    fill(8'h20);
    mem[3] = 8'h41;
    mem[9] = 8'h7B;
    run_scan(-1, -1, lat);
    chk("two_bad_latency", 32'(lat), COUNT_EN ? 32'd64 : 32'd8);
    chk("two_bad_fail_index", 32'(fail_index), 32'd3);
    chk("two_bad_bad_char", 32'(bad_char), 32'h41);
`ifdef RESULT_CHECK_COUNT_EN
    chk("two_bad_bad_count", 32'(bad_count), 32'd2);
`endif

    // start while busy is ignored.
    fill(8'h6D);
    run_scan(5, 20, lat);
    chk("ignored_start_latency", 32'(lat), 32'd64);
    chk("ignored_start_pass", 32'(pass), 32'd1);

    // Restart from DONE with different content.
    mem[0] = 8'h2E;
    run_scan(-1, -1, lat);
    chk("restart_latency", 32'(lat), COUNT_EN ? 32'd64 : 32'd2);
    chk("restart_fail_index", 32'(fail_index), 32'd0);
    chk("restart_bad_char", 32'(bad_char), 32'h2E);

    // Reset in the middle of a scan.
    fill(8'h61);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_addr", 32'(ram_addr), 32'd0);
    chk("midreset_pass", 32'(pass), 32'd0);
    chk("midreset_state", 32'(state_dbg), 32'(IDLE));
    run_scan(-1, -1, lat);
    chk("after_reset_latency", 32'(lat), 32'd64);
    chk("after_reset_pass", 32'(pass), 32'd1);

    // Random content, checked cycle by cycle against the model.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_byte();
      run_scan(-1, -1, lat);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
